// File: rtl/rsa_key_ctrl_if.sv
// Host and engine-side signal bundle for the RSA key setup sequencer.
// The slave modport is the sequencer's view; master is the host/engine view.
interface rsa_key_ctrl_if #(
  parameter int WIDTH = 8
);
  logic               req;
  logic [WIDTH-1:0]   p;
  logic [WIDTH-1:0]   q;
  logic               busy;
  logic               key_valid;
  logic               err;
  logic [1:0]         err_code;
  logic [WIDTH-1:0]   e_out;
  logic [2*WIDTH-1:0] d_out;
  logic [2*WIDTH-1:0] n_out;
  logic               kg_start;
  logic [WIDTH-1:0]   kg_p;
  logic [WIDTH-1:0]   kg_q;
  logic [WIDTH-1:0]   kg_e;
  logic               kg_finish;
  logic               inv_start;
  logic [WIDTH-1:0]   inv_e;
  logic [2*WIDTH-1:0] inv_phi;
  logic [2*WIDTH-1:0] inv_d;
  logic               inv_finish;
  logic               inv_fail;

  modport slave (
    input  req, p, q, kg_e, kg_finish,
    input  inv_d, inv_finish, inv_fail,
    output busy, key_valid, err, err_code,
    output e_out, d_out, n_out,
    output kg_start, kg_p, kg_q,
    output inv_start, inv_e, inv_phi
  );

  modport master (
    output req, p, q, kg_e, kg_finish,
    output inv_d, inv_finish, inv_fail,
    input  busy, key_valid, err, err_code,
    input  e_out, d_out, n_out,
    input  kg_start, kg_p, kg_q,
    input  inv_start, inv_e, inv_phi
  );
endinterface

// File: rtl/rsa_key_ctrl.sv
// RSA key setup sequencer: validates p/q, forms n and phi, then runs
// KeyGen and the modular-inverse engine with a per-engine timeout.
module rsa_key_ctrl #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input logic           clk,
  input logic           rst,
  rsa_key_ctrl_if.slave bus
);
  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] MIN_PQ = WIDTH'(3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KG_START,
    S_KG_WAIT,
    S_INV_START,
    S_INV_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      code_q, code_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [DW-1:0]   d_q, d_d;
  logic [DW-1:0]   n_q, n_d;
  logic [DW-1:0]   phi_q, phi_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic            busy_q, busy_d;
  logic            kv_q, kv_d;
  logic            err_q, err_d;
  logic            kgs_q, kgs_d;
  logic            invs_q, invs_d;

  logic             bad;
  logic [WIDTH-1:0] pm1;
  logic [WIDTH-1:0] qm1;

  assign bad = (bus.p < MIN_PQ) || (bus.q < MIN_PQ)
            || (bus.p == bus.q);
  assign pm1 = bus.p - WIDTH'(1);
  assign qm1 = bus.q - WIDTH'(1);

  // Next-state, counter and latched-data decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    e_d     = e_q;
    d_d     = d_q;
    n_d     = n_q;
    phi_d   = phi_q;
    p_d     = p_q;
    q_d     = q_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.req) begin
          code_d = 2'b00;
          e_d    = '0;
          d_d    = '0;
          if (bad) begin
            state_d = S_ERR;
            code_d  = 2'b01;
          end else begin
            p_d     = bus.p;
            q_d     = bus.q;
            n_d     = DW'(bus.p) * DW'(bus.q);
            phi_d   = DW'(pm1) * DW'(qm1);
            state_d = S_KG_START;
          end
        end
      end
      S_KG_START: begin
        state_d = S_KG_WAIT;
        cnt_d   = '0;
      end
      S_KG_WAIT: begin
        if (bus.kg_finish) begin
          e_d     = bus.kg_e;
          state_d = S_INV_START;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
          code_d  = 2'b10;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_INV_START: begin
        state_d = S_INV_WAIT;
        cnt_d   = '0;
      end
      S_INV_WAIT: begin
        if (bus.inv_finish) begin
          if (bus.inv_fail) begin
            state_d = S_ERR;
            code_d  = 2'b11;
          end else begin
            d_d     = bus.inv_d;
            state_d = S_DONE;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
          code_d  = 2'b11;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore status outputs, registered from the next state.
  always_comb begin
    busy_d = (state_d == S_KG_START) || (state_d == S_KG_WAIT)
          || (state_d == S_INV_START) || (state_d == S_INV_WAIT);
    kv_d   = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
    kgs_d  = (state_d == S_KG_START);
    invs_d = (state_d == S_INV_START);
  end

  // State and output registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      e_q     <= '0;
      d_q     <= '0;
      n_q     <= '0;
      phi_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      kv_q    <= 1'b0;
      err_q   <= 1'b0;
      kgs_q   <= 1'b0;
      invs_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      e_q     <= e_d;
      d_q     <= d_d;
      n_q     <= n_d;
      phi_q   <= phi_d;
      p_q     <= p_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      kv_q    <= kv_d;
      err_q   <= err_d;
      kgs_q   <= kgs_d;
      invs_q  <= invs_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.key_valid = kv_q;
  assign bus.err       = err_q;
  assign bus.err_code  = code_q;
  assign bus.e_out     = e_q;
  assign bus.d_out     = d_q;
  assign bus.n_out     = n_q;
  assign bus.kg_start  = kgs_q;
  assign bus.kg_p      = p_q;
  assign bus.kg_q      = q_q;
  assign bus.inv_start = invs_q;
  assign bus.inv_e     = e_q;
  assign bus.inv_phi   = phi_q;
endmodule

// File: tb/tb_rsa_key_ctrl.sv
// Bench for rsa_key_ctrl: cycle-level behavioural model, engine responders,
// directed scenarios plus randomized key requests.
module tb_rsa_key_ctrl;
  localparam int W  = 8;
  localparam int TO = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           req = 1'b0;
  logic [W-1:0]   p = '0, q = '0;
  logic [W-1:0]   kg_e = '0;
  logic           kg_finish = 1'b0;
  logic [2*W-1:0] inv_d = '0;
  logic           inv_finish = 1'b0;
  logic           inv_fail = 1'b0;

  rsa_key_ctrl_if #(.WIDTH(W)) bus ();
  assign bus.req        = req;
  assign bus.p          = p;
  assign bus.q          = q;
  assign bus.kg_e       = kg_e;
  assign bus.kg_finish  = kg_finish;
  assign bus.inv_d      = inv_d;
  assign bus.inv_finish = inv_finish;
  assign bus.inv_fail   = inv_fail;

  rsa_key_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: phase of the key-setup run plus the values the host should see.
  typedef enum {M_IDLE, M_KS, M_KW, M_IS, M_IW, M_DONE, M_ERR} mph_t;
  mph_t ph = M_IDLE;
  int   waited = 0;
  int   m_code = 0, m_e = 0, m_d = 0, m_n = 0, m_phi = 0;
  int   m_kp = 0, m_kq = 0;

  task automatic model_step();
    if (rst) begin
      ph = M_IDLE; waited = 0; m_code = 0; m_e = 0; m_d = 0;
      m_n = 0; m_phi = 0; m_kp = 0; m_kq = 0;
      return;
    end
    case (ph)
      M_IDLE, M_DONE, M_ERR:
        if (req) begin
          m_code = 0; m_e = 0; m_d = 0;
          if (int'(p) < 3 || int'(q) < 3 || p == q) begin
            ph = M_ERR; m_code = 1;
          end else begin
            m_kp = p; m_kq = q;
            m_n = int'(p) * int'(q);
            m_phi = (int'(p) - 1) * (int'(q) - 1);
            ph = M_KS;
          end
        end
      M_KS: begin ph = M_KW; waited = 0; end
      M_IS: begin ph = M_IW; waited = 0; end
      M_KW: begin
        waited++;
        if (kg_finish) begin m_e = kg_e; ph = M_IS; end
        else if (waited == TO) begin ph = M_ERR; m_code = 2; end
      end
      M_IW: begin
        waited++;
        if (inv_finish && !inv_fail) begin m_d = inv_d; ph = M_DONE; end
        else if (inv_finish || waited == TO) begin ph = M_ERR; m_code = 3; end
      end
      default: ph = M_IDLE;
    endcase
  endtask

  int cyc = 0, n_ks = 0, n_is = 0, ks_cyc = 0, err_cyc = 0;
  logic err_prev = 1'b0;

  task automatic compare();
    logic mb;
    mb = (ph == M_KS || ph == M_KW || ph == M_IS || ph == M_IW);
    chk("busy", bus.busy, mb);
    chk("key_valid", bus.key_valid, ph == M_DONE);
    chk("err", bus.err, ph == M_ERR);
    chk("err_code", bus.err_code, m_code);
    chk("e_out", bus.e_out, m_e);
    chk("d_out", bus.d_out, m_d);
    chk("n_out", bus.n_out, m_n);
    chk("kg_start", bus.kg_start, ph == M_KS);
    chk("kg_p", bus.kg_p, m_kp);
    chk("kg_q", bus.kg_q, m_kq);
    chk("inv_start", bus.inv_start, ph == M_IS);
    chk("inv_e", bus.inv_e, m_e);
    chk("inv_phi", bus.inv_phi, m_phi);
    if (bus.kg_start === 1'b1) begin n_ks++; ks_cyc = cyc; end
    if (bus.inv_start === 1'b1) n_is++;
    if (bus.err === 1'b1 && !err_prev) err_cyc = cyc;
    err_prev = (bus.err === 1'b1);
  endtask

  // Engine responders: answer a fixed number of cycles after the start
  // pulse (0 = never answer), optionally with stray finishes elsewhere.
  int kg_delay = 0, kg_left = 0, kg_val = 0;
  int inv_delay = 0, inv_left = 0, inv_val = 0;
  bit inv_fl = 0, stray_on = 0;

  task automatic engines();
    kg_finish = 0; inv_finish = 0; inv_fail = 0;
    kg_e = W'($urandom); inv_d = (2*W)'($urandom);
    if (rst) begin kg_left = 0; inv_left = 0; return; end
    if (ph == M_KS) kg_left = kg_delay;
    else if (kg_left > 0) begin
      kg_left--;
      if (kg_left == 0) begin kg_finish = 1; kg_e = W'(kg_val); end
    end
    if (ph == M_IS) inv_left = inv_delay;
    else if (inv_left > 0) begin
      inv_left--;
      if (inv_left == 0) begin
        inv_finish = 1; inv_fail = inv_fl; inv_d = (2*W)'(inv_val);
      end
    end
    if (stray_on && ph != M_KW && $urandom_range(0, 3) == 0)
      kg_finish = 1;
    if (stray_on && ph != M_IW && $urandom_range(0, 3) == 0) begin
      inv_finish = 1; inv_fail = 1'($urandom);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    compare();
    engines();
  endtask

  task automatic run(input int pp, input int qq, input int kd,
                     input int ke, input int id, input int idv,
                     input bit fl, input bit stray);
    kg_delay = kd; kg_val = ke; inv_delay = id; inv_val = idv;
    inv_fl = fl; stray_on = stray;
    req = 1; p = W'(pp); q = W'(qq);
    tick();
    req = 0;
    for (int i = 0; i < 4 * TO + 10; i++) begin
      if (ph == M_DONE || ph == M_ERR) break;
      if (stray) begin
        req = 1'($urandom); p = W'($urandom); q = W'($urandom);
      end
      tick();
    end
    req = 0; stray_on = 0;
    if (!(ph == M_DONE || ph == M_ERR)) begin
      checks++; errors++;
      $display("FAIL run_bound: run did not end, phase %0d", ph);
    end
  endtask

  task automatic pin_61_53();
    chk("model_n", m_n, 3233);
    chk("model_phi", m_phi, 3120);
    chk("pin_n_out", bus.n_out, 3233);
    chk("pin_inv_phi", bus.inv_phi, 3120);
    chk("pin_e_out", bus.e_out, 7);
    chk("pin_d_out", bus.d_out, 1783);
    chk("pin_key_valid", bus.key_valid, 1);
    chk("pin_err", bus.err, 0);
  endtask

  int ks0, is0;

  initial begin
    rst = 1;
    repeat (3) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_n_out", bus.n_out, 0);
    rst = 0;
    tick();

    // Nominal 61/53 key.
    run(61, 53, 20, 7, 30, 1783, 0, 0);
    pin_61_53();
    repeat (3) tick();

    // Bad inputs.
    ks0 = n_ks;
    run(53, 53, 5, 1, 5, 1, 0, 0);
    chk("bad_eq_code", bus.err_code, 1);
    run(2, 53, 5, 1, 5, 1, 0, 0);
    chk("bad_small_code", bus.err_code, 1);
    chk("bad_no_kg_start", n_ks - ks0, 0);

    // KeyGen never answers.
    is0 = n_is;
    run(61, 53, 0, 7, 5, 1, 0, 0);
    chk("kg_to_code", bus.err_code, 2);
    chk("kg_wait_cycles", err_cyc - ks_cyc - 1, TO);
    chk("kg_to_no_inv_start", n_is - is0, 0);

    // Inverse reports failure.
    run(61, 53, 5, 7, 8, 1234, 1, 0);
    chk("inv_fail_code", bus.err_code, 3);
    chk("inv_fail_d", bus.d_out, 0);
    chk("inv_fail_kv", bus.key_valid, 0);

    // Stray req/finish while busy; one kg_start per accept.
    ks0 = n_ks;
    run(61, 53, 10, 7, 12, 1783, 0, 1);
    chk("stray_one_kg_start", n_ks - ks0, 1);
    chk("stray_kv", bus.key_valid, 1);

    // Finish on the last allowed wait cycle wins; one later times out.
    run(61, 53, TO, 9, TO, 500, 0, 0);
    chk("edge_kv", bus.key_valid, 1);
    chk("edge_e", bus.e_out, 9);
    chk("edge_d", bus.d_out, 500);
    run(61, 53, TO + 1, 9, 5, 1, 0, 0);
    chk("edge_kg_to", bus.err_code, 2);
    run(61, 53, 4, 9, TO + 1, 1, 0, 0);
    chk("edge_inv_to", bus.err_code, 3);

    // Reset while waiting on the inverse engine.
    kg_delay = 3; kg_val = 7; inv_delay = 0; inv_fl = 0;
    req = 1; p = 61; q = 53;
    tick();
    req = 0;
    for (int i = 0; i < 20 && ph != M_IW; i++) tick();
    chk("reached_inv_wait", bus.busy, 1);
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_n", bus.n_out, 0);
    chk("rst_mid_e", bus.e_out, 0);
    tick();
    chk("rst_after_kg_start", bus.kg_start, 0);
    run(61, 53, 20, 7, 30, 1783, 0, 0);
    pin_61_53();

    // Randomized requests, including back-to-back from DONE/ERR.
    for (int t = 0; t < 40; t++) begin
      int pp, qq;
      pp = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5)
                                       : $urandom_range(3, 255);
      qq = ($urandom_range(0, 3) == 0) ? pp : $urandom_range(0, 255);
      run(pp, qq, $urandom_range(0, TO + 2), $urandom_range(0, 255),
          $urandom_range(0, TO + 2), $urandom_range(0, 65535),
          ($urandom_range(0, 3) == 0), 1'($urandom));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
